conv_layer_engine: RTL and testbench

Parametrised convolution layer for the CNN accelerator. It generalises the fixed four-filter, externally sequenced layer datapath in three ways: kernel size, channel count, image size and stride are parameters; the sequencing FSM is internal; results leave through a valid/ready stream. It holds one input feature map and N kernels in internal buffers, slides a K×K window over the map, and emits one N-channel result per window position.

---
 rtl/conv_layer_engine.sv | 167 ++++++++++++++++
 tb/tb_conv_layer_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_engine.sv
// Convolution layer engine: buffers one feature map plus N KxK kernels, slides the
// window in raster order and streams one N-channel result per window position.
module conv_layer_engine #(
  parameter int DW     = 8,
  parameter int ACC_W  = 24,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int K      = 3,
  parameter int N      = 4,
  parameter int STRIDE = 1,
  parameter int RELU   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              px_we,
  input  logic [$clog2(IMG_W*IMG_H)-1:0]    px_addr,
  input  logic [DW-1:0]                     px_data,
  input  logic                              w_we,
  input  logic [$clog2(N*K*K)-1:0]          w_addr,
  input  logic [DW-1:0]                     w_data,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N*ACC_W-1:0]                out_data,
  output logic [$clog2(IMG_W)-1:0]          out_x,
  output logic [$clog2(IMG_H)-1:0]          out_y,
  output logic                              done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int KK   = K * K;
  localparam int NW   = N * KK;
  localparam int PA_W = $clog2(NPIX);
  localparam int WA_W = $clog2(NW);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int KW   = $clog2(K + 1);
  localparam int OW   = (IMG_W - K) / STRIDE + 1;
  localparam int OH   = (IMG_H - K) / STRIDE + 1;
  localparam int PW   = 2 * DW + 1;

  // Result stream: a result transfers on any rising edge where out_valid and
  // out_ready are both high; until then out_data/out_x/out_y hold steady.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;
  state_t state, state_nx;

  logic [KW-1:0] kx, ky;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic          last_tap, last_pos, hs, fetch, clear_acc, rd_v;

  assign last_tap = (kx == KW'(K - 1)) && (ky == KW'(K - 1));
  assign last_pos = (ox == XW'(OW - 1)) && (oy == YW'(OH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (last_tap) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = last_pos ? S_IDLE : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    out_valid = (state == S_OUT);
    fetch     = (state == S_FETCH);
    hs        = out_valid && out_ready;
    clear_acc = ((state == S_IDLE) && start) || (hs && !last_pos);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx   <= '0;
      ky   <= '0;
      ox   <= '0;
      oy   <= '0;
      rd_v <= 1'b0;
      done <= 1'b0;
    end else begin
      rd_v <= fetch;
      done <= hs && last_pos;
      if ((state == S_IDLE) && start) begin
        kx <= '0;
        ky <= '0;
        ox <= '0;
        oy <= '0;
      end else if (fetch) begin
        if (kx == KW'(K - 1)) begin
          kx <= '0;
          ky <= (ky == KW'(K - 1)) ? '0 : ky + KW'(1);
        end else begin
          kx <= kx + KW'(1);
        end
      end else if (hs && !last_pos) begin
        if (ox == XW'(OW - 1)) begin
          ox <= '0;
          oy <= oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
    end
  end

  logic [PA_W-1:0] pix_idx;
  logic [31:0]     tap;

  always_comb begin
    tap     = 32'(ky) * K + 32'(kx);
    pix_idx = PA_W'((32'(oy) * STRIDE + 32'(ky)) * IMG_W + 32'(ox) * STRIDE + 32'(kx));
  end

  // Buffers keep their contents across rst so a layer can be rerun without reloading.
  logic [DW-1:0] pix_mem [NPIX];
  logic [DW-1:0] w_mem   [NW];
  logic [DW-1:0] pix_q;
  logic [DW-1:0] w_q     [N];

  always_ff @(posedge clk) begin
    if (px_we && !busy && (32'(px_addr) < NPIX)) pix_mem[px_addr] <= px_data;
    if (w_we && !busy && (32'(w_addr) < NW)) w_mem[w_addr] <= w_data;
    pix_q <= pix_mem[pix_idx];
    for (int c = 0; c < N; c++) w_q[c] <= w_mem[WA_W'(32'(c * KK) + tap)];
  end

  // Unsigned pixel times signed weight, done on sign-extended operands so the
  // low PW bits of the product are the exact signed result.
  logic [PW-1:0]    prod     [N];
  logic [ACC_W-1:0] prod_ext [N];
  logic [ACC_W-1:0] acc      [N];

  always_comb begin
    for (int c = 0; c < N; c++) begin
      prod[c]     = {{DW{1'b0}}, 1'b0, pix_q} * {{(DW + 1){w_q[c][DW-1]}}, w_q[c]};
      prod_ext[c] = {{(ACC_W - PW){prod[c][PW-1]}}, prod[c]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N; c++) acc[c] <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (clear_acc) acc[c] <= '0;
        else if (rd_v) acc[c] <= acc[c] + prod_ext[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++)
      out_data[c*ACC_W +: ACC_W] = ((RELU != 0) && acc[c][ACC_W-1]) ? '0 : acc[c];
  end

  assign out_x = ox;
  assign out_y = oy;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Bench for conv_layer_engine: a default instance and a STRIDE=2/RELU=0 instance
// share the load bus and are both checked against an arithmetic convolution model.
module tb_conv_layer_engine;

  localparam int DW = 8, ACC_W = 24, IMG_W = 10, IMG_H = 10, K = 3, N = 4;
  localparam int RW = N * ACC_W + 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, px_we = 1'b0, w_we = 1'b0;
  logic out_ready = 1'b0, start_a_only = 1'b0, start_b;
  logic [6:0] px_addr = '0;
  logic [7:0] px_data = '0, w_data = '0;
  logic [5:0] w_addr = '0;

  logic busy_a, out_valid_a, done_a, busy_b, out_valid_b, done_b;
  logic [N*ACC_W-1:0] out_data_a, out_data_b;
  logic [3:0] out_x_a, out_y_a, out_x_b, out_y_b;

  assign start_b = start & ~start_a_only;

  always #5 clk = ~clk;

  conv_layer_engine dut_a (
    .clk(clk), .rst(rst), .start(start), .px_we(px_we), .px_addr(px_addr), .px_data(px_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_x(out_x_a), .out_y(out_y_a), .done(done_a));

  conv_layer_engine #(.STRIDE(2), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .px_we(px_we), .px_addr(px_addr), .px_data(px_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_x(out_x_b), .out_y(out_y_b), .done(done_b));

  int n_checks = 0, n_fail = 0;
  logic [RW-1:0] exp_qa[$], exp_qb[$];
  int pix_m[IMG_W*IMG_H];
  int w_m[N][K*K];

  int cnt_a, cnt_b, done_cnt_a, done_cnt_b, done_rel_a, done_rel_b, first_rel_a, rel, hold_checks;
  logic busy_at1;
  logic [RW-1:0] va, vb, first_a, first_b, hold_a, hold_b;
  logic [RW-1:0] got_a[64], got_b[16];
  logic hold_a_v = 1'b0, hold_b_v = 1'b0;

  typedef struct {
    int         pix;
    int         w0;
    logic [23:0] exp_a0;
    logic [23:0] exp_b0;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Reference: direct convolution sum over the window, then optional clamp.
  task automatic build_exp(input int s, input bit relu, input bit to_b);
    int ow, oh, sum;
    logic [RW-1:0] v;
    ow = (IMG_W - K) / s + 1;
    oh = (IMG_H - K) / s + 1;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        v = '0;
        for (int c = 0; c < N; c++) begin
          sum = 0;
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              sum += pix_m[(oy * s + ky) * IMG_W + ox * s + kx] * w_m[c][ky * K + kx];
          if (relu && sum < 0) sum = 0;
          v[c*ACC_W +: ACC_W] = ACC_W'(sum);
        end
        v[N*ACC_W +: 4]     = 4'(ox);
        v[N*ACC_W + 4 +: 4] = 4'(oy);
        if (to_b) exp_qb.push_back(v);
        else      exp_qa.push_back(v);
      end
    end
  endtask

  always @(negedge clk) begin
    va = {out_y_a, out_x_a, out_data_a};
    vb = {out_y_b, out_x_b, out_data_b};
    if (rst) begin
      hold_a_v = 1'b0;
      hold_b_v = 1'b0;
    end else begin
      if (start && !busy_a) rel = 0;
      else rel++;
      if (rel == 1) busy_at1 = busy_a;
      if (hold_a_v) begin
        hold_checks++;
        check("a_hold", 128'({out_valid_a, va}), 128'({1'b1, hold_a}));
      end
      if (hold_b_v) check("b_hold", 128'({out_valid_b, vb}), 128'({1'b1, hold_b}));
      if (out_valid_a && first_rel_a < 0) first_rel_a = rel;
      if (out_valid_a && out_ready) begin
        if (cnt_a == 0) first_a = va;
        if (cnt_a < 64) got_a[cnt_a] = va;
        cnt_a++;
        if (exp_qa.size() == 0) fail_now("a_extra_result");
        else check("a_result", 128'(va), 128'(exp_qa.pop_front()));
      end
      if (out_valid_b && out_ready) begin
        if (cnt_b == 0) first_b = vb;
        if (cnt_b < 16) got_b[cnt_b] = vb;
        cnt_b++;
        if (exp_qb.size() == 0) fail_now("b_extra_result");
        else check("b_result", 128'(vb), 128'(exp_qb.pop_front()));
      end
      hold_a_v = out_valid_a && !out_ready;
      hold_a   = va;
      hold_b_v = out_valid_b && !out_ready;
      hold_b   = vb;
      if (done_a) begin done_cnt_a++; done_rel_a = rel; end
      if (done_b) begin done_cnt_b++; done_rel_b = rel; end
    end
  end

  task automatic wr_px(input int a, input int v);
    px_we = 1'b1; px_addr = 7'(a); px_data = 8'(v);
    @(posedge clk); #1;
    px_we = 1'b0;
    pix_m[a] = v;
  endtask

  task automatic wr_w(input int c, input int t, input int v);
    w_we = 1'b1; w_addr = 6'(c * K * K + t); w_data = 8'(v);
    @(posedge clk); #1;
    w_we = 1'b0;
    w_m[c][t] = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a"}, 128'({busy_a, out_valid_a, done_a, out_x_a, out_y_a, out_data_a}), 128'(0));
    check({tag, "_b"}, 128'({busy_b, out_valid_b, done_b, out_x_b, out_y_b, out_data_b}), 128'(0));
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall at first result;
  // 3: start/write pulses while busy; 4: reset mid-FETCH of the 10th result.
  task automatic run_pass(input int mode);
    int budget, bp_left, rcnt;
    bit bp_used;
    exp_qa.delete();
    exp_qb.delete();
    build_exp(1, 1'b1, 1'b0);
    build_exp(2, 1'b0, 1'b1);
    cnt_a = 0; cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    done_rel_a = -1; done_rel_b = -1; first_rel_a = -1; hold_checks = 0; busy_at1 = 1'b0;
    start = 1'b1;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bp_left = 5; bp_used = 1'b0; rcnt = 0; budget = 0;
    while (budget < 5000 && !(done_cnt_a > 0 && done_cnt_b > 0)) begin
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid_a && !bp_used) begin
            out_ready = 1'b0;
            bp_left--;
            if (bp_left == 0) bp_used = 1'b1;
          end else out_ready = 1'b1;
        end
        3: begin
          out_ready = 1'b1;
          if (budget == 30 || budget == 100) begin
            start = 1'b1; px_we = 1'b1; px_addr = 7'(budget); px_data = 8'hAA;
            w_we = 1'b1; w_addr = '0; w_data = 8'h55;
          end else begin
            start = 1'b0; px_we = 1'b0; w_we = 1'b0;
          end
          if (out_valid_a && cnt_a == 63) begin
            start = 1'b1;
            start_a_only = 1'b1;
          end
        end
        4: begin
          out_ready = 1'b1;
          if (cnt_a >= 9) rcnt++;
          if (rcnt == 4) begin
            rst = 1'b1;
            break;
          end
        end
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0; px_we = 1'b0; w_we = 1'b0;
    if (budget >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: got no done within 5000 cycles expected done (mode %0d)", mode);
    end
    if (mode == 4) begin
      @(negedge clk);
      check_zero_outputs("mid_reset");
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      repeat (3) @(posedge clk);
      #1;
      start_a_only = 1'b0;
      check("a_count", 128'(cnt_a), 128'(64));
      check("b_count", 128'(cnt_b), 128'(16));
      check("a_done_once", 128'(done_cnt_a), 128'(1));
      check("b_done_once", 128'(done_cnt_b), 128'(1));
      check("a_queue_empty", 128'(exp_qa.size()), 128'(0));
      check("b_queue_empty", 128'(exp_qb.size()), 128'(0));
      check("a_idle_after", 128'(busy_a), 128'(0));
      if (mode == 0 || mode == 3) begin
        check("a_done_cycle", 128'(done_rel_a), 128'(64 * 11 + 1));
        check("b_done_cycle", 128'(done_rel_b), 128'(16 * 11 + 1));
        check("a_first_valid_cycle", 128'(first_rel_a), 128'(11));
        check("a_busy_cycle1", 128'(busy_at1), 128'(1));
      end
      if (mode == 2) check("a_stall_cycles", 128'(hold_checks), 128'(5));
    end
  endtask

  task automatic load_uniform(input int p, input int w0);
    for (int a = 0; a < IMG_W * IMG_H; a++) wr_px(a, p);
    for (int c = 0; c < N; c++)
      for (int t = 0; t < K * K; t++) wr_w(c, t, (c == 0) ? w0 : c + 1);
  endtask

  task automatic load_random();
    for (int a = 0; a < IMG_W * IMG_H; a++) wr_px(a, int'($urandom_range(0, 255)));
    for (int c = 0; c < N; c++)
      for (int t = 0; t < K * K; t++) wr_w(c, t, int'($urandom_range(0, 255)) - 128);
  endtask

  initial begin
    vecs[0] = '{pix: 1,   w0: 1,    exp_a0: 24'd9,       exp_b0: 24'd9};
    vecs[1] = '{pix: 5,   w0: -1,   exp_a0: 24'd0,       exp_b0: 24'hFFFFD3};
    vecs[2] = '{pix: 255, w0: 127,  exp_a0: 24'h047289,  exp_b0: 24'h047289};
    vecs[3] = '{pix: 255, w0: -128, exp_a0: 24'd0,       exp_b0: 24'hFB8480};
    vecs[4] = '{pix: 0,   w0: 77,   exp_a0: 24'd0,       exp_b0: 24'd0};

    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      load_uniform(vecs[i].pix, vecs[i].w0);
      run_pass(0);
      check("tbl_a_ch0", 128'(first_a[23:0]), 128'(vecs[i].exp_a0));
      check("tbl_b_ch0", 128'(first_b[23:0]), 128'(vecs[i].exp_b0));
    end

    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) wr_px(y * IMG_W + x, x + 10 * y);
    for (int t = 0; t < K * K; t++) wr_w(0, t, (t == 4) ? 1 : 0);
    for (int c = 1; c < N; c++)
      for (int t = 0; t < K * K; t++) wr_w(c, t, int'($urandom_range(0, 255)) - 128);
    run_pass(0);
    check("stride_b_3_3", 128'(got_b[15][23:0]), 128'(77));
    check("stride_b_0_0", 128'(got_b[0][23:0]), 128'(11));
    check("stride1_a_3_3", 128'(got_a[27][23:0]), 128'(44));

    for (int i = 0; i < 2; i++) begin
      load_random();
      run_pass(1);
    end

    run_pass(2);
    run_pass(3);
    run_pass(4);
    run_pass(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
